// File: rtl/ram_access_mux.sv
// ram_access_mux: steers the single data-RAM port to the I/S/A/F channel
// selected by the current opcode, and returns read data to that channel only.
// Ports: iCLK/iRST (sync, active-high); OPCODE selects the channel;
//   iRAM_*_x are channel requests, oRAM_DATA_RD_x are per-channel read data;
//   oRAM_* drive the RAM and iRAM_DATA_RD is its read data;
//   oSEL is the channel id registered from the previous cycle.
module ram_access_mux #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic [6:0]    OPCODE,
   input  logic          iRAM_CE_I,
   input  logic          iRAM_RD_I,
   input  logic          iRAM_WR_I,
   input  logic [AW-1:0] iRAM_ADDR_I,
   input  logic [DW-1:0] iRAM_DATA_WR_I,
   output logic [DW-1:0] oRAM_DATA_RD_I,
   input  logic          iRAM_CE_S,
   input  logic          iRAM_RD_S,
   input  logic          iRAM_WR_S,
   input  logic [AW-1:0] iRAM_ADDR_S,
   input  logic [DW-1:0] iRAM_DATA_WR_S,
   output logic [DW-1:0] oRAM_DATA_RD_S,
   input  logic          iRAM_CE_A,
   input  logic          iRAM_RD_A,
   input  logic          iRAM_WR_A,
   input  logic [AW-1:0] iRAM_ADDR_A,
   input  logic [DW-1:0] iRAM_DATA_WR_A,
   output logic [DW-1:0] oRAM_DATA_RD_A,
   input  logic          iRAM_CE_F,
   input  logic          iRAM_RD_F,
   input  logic          iRAM_WR_F,
   input  logic [AW-1:0] iRAM_ADDR_F,
   input  logic [DW-1:0] iRAM_DATA_WR_F,
   output logic [DW-1:0] oRAM_DATA_RD_F,
   output logic          oRAM_CE,
   output logic          oRAM_RD,
   output logic          oRAM_WR,
   output logic [AW-1:0] oRAM_ADDR,
   output logic [DW-1:0] oRAM_DATA_WR,
   input  logic [DW-1:0] iRAM_DATA_RD,
   output logic [2:0]    oSEL
);

   typedef enum logic [2:0] {
      SEL_NONE = 3'd0,
      SEL_I    = 3'd1,
      SEL_S    = 3'd2,
      SEL_A    = 3'd3,
      SEL_F    = 3'd4
   } sel_e;

   sel_e sel;

   // Equality compares make any X opcode bit fall through to NONE.
   // Reset gates the decode so the RAM goes idle in the same cycle.
   always_comb begin
      sel = SEL_NONE;
      if (iRST)
         sel = SEL_NONE;
      else if (OPCODE == 7'b0000011)
         sel = SEL_I;
      else if (OPCODE == 7'b0100011)
         sel = SEL_S;
      else if (OPCODE == 7'b0101111)
         sel = SEL_A;
      else if (OPCODE == 7'b0000111 || OPCODE == 7'b0100111)
         sel = SEL_F;
   end

   always_comb begin
      oRAM_CE        = 1'b0;
      oRAM_RD        = 1'b0;
      oRAM_WR        = 1'b0;
      oRAM_ADDR      = '0;
      oRAM_DATA_WR   = '0;
      oRAM_DATA_RD_I = '0;
      oRAM_DATA_RD_S = '0;
      oRAM_DATA_RD_A = '0;
      oRAM_DATA_RD_F = '0;
      case (sel)
         SEL_I: begin
            oRAM_CE        = iRAM_CE_I;
            oRAM_RD        = iRAM_RD_I;
            oRAM_WR        = iRAM_WR_I;
            oRAM_ADDR      = iRAM_ADDR_I;
            oRAM_DATA_WR   = iRAM_DATA_WR_I;
            oRAM_DATA_RD_I = iRAM_DATA_RD;
         end
         SEL_S: begin
            oRAM_CE        = iRAM_CE_S;
            oRAM_RD        = iRAM_RD_S;
            oRAM_WR        = iRAM_WR_S;
            oRAM_ADDR      = iRAM_ADDR_S;
            oRAM_DATA_WR   = iRAM_DATA_WR_S;
            oRAM_DATA_RD_S = iRAM_DATA_RD;
         end
         SEL_A: begin
            oRAM_CE        = iRAM_CE_A;
            oRAM_RD        = iRAM_RD_A;
            oRAM_WR        = iRAM_WR_A;
            oRAM_ADDR      = iRAM_ADDR_A;
            oRAM_DATA_WR   = iRAM_DATA_WR_A;
            oRAM_DATA_RD_A = iRAM_DATA_RD;
         end
         SEL_F: begin
            oRAM_CE        = iRAM_CE_F;
            oRAM_RD        = iRAM_RD_F;
            oRAM_WR        = iRAM_WR_F;
            oRAM_ADDR      = iRAM_ADDR_F;
            oRAM_DATA_WR   = iRAM_DATA_WR_F;
            oRAM_DATA_RD_F = iRAM_DATA_RD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST)
         oSEL <= 3'd0;
      else
         oSEL <= sel;
   end

endmodule

// File: tb/tb_ram_access_mux.sv
// tb_ram_access_mux: directed and randomized checks of ram_access_mux
// against an opcode-table reference model.
module tb_ram_access_mux;
   localparam int AW = 8;
   localparam int DW = 32;

   logic          iCLK = 1'b0;
   logic          iRST;
   logic [6:0]    OPCODE;
   logic          ce  [4];
   logic          rd  [4];
   logic          wr  [4];
   logic [AW-1:0] addr[4];
   logic [DW-1:0] dwr [4];
   logic [DW-1:0] rdo [4];
   logic          oRAM_CE, oRAM_RD, oRAM_WR;
   logic [AW-1:0] oRAM_ADDR;
   logic [DW-1:0] oRAM_DATA_WR;
   logic [DW-1:0] iRAM_DATA_RD;
   logic [2:0]    oSEL;

   int checks = 0;
   int errors = 0;

   always #5 iCLK = ~iCLK;

   ram_access_mux #(.AW(AW), .DW(DW)) dut (
      .iCLK(iCLK), .iRST(iRST), .OPCODE(OPCODE),
      .iRAM_CE_I(ce[0]), .iRAM_RD_I(rd[0]), .iRAM_WR_I(wr[0]),
      .iRAM_ADDR_I(addr[0]), .iRAM_DATA_WR_I(dwr[0]),
      .oRAM_DATA_RD_I(rdo[0]),
      .iRAM_CE_S(ce[1]), .iRAM_RD_S(rd[1]), .iRAM_WR_S(wr[1]),
      .iRAM_ADDR_S(addr[1]), .iRAM_DATA_WR_S(dwr[1]),
      .oRAM_DATA_RD_S(rdo[1]),
      .iRAM_CE_A(ce[2]), .iRAM_RD_A(rd[2]), .iRAM_WR_A(wr[2]),
      .iRAM_ADDR_A(addr[2]), .iRAM_DATA_WR_A(dwr[2]),
      .oRAM_DATA_RD_A(rdo[2]),
      .iRAM_CE_F(ce[3]), .iRAM_RD_F(rd[3]), .iRAM_WR_F(wr[3]),
      .iRAM_ADDR_F(addr[3]), .iRAM_DATA_WR_F(dwr[3]),
      .oRAM_DATA_RD_F(rdo[3]),
      .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR),
      .oRAM_ADDR(oRAM_ADDR), .oRAM_DATA_WR(oRAM_DATA_WR),
      .iRAM_DATA_RD(iRAM_DATA_RD), .oSEL(oSEL)
   );

   // Reference: memory opcodes and the channel id each one owns.
   logic [6:0] op_tab [5] = '{7'b0000011, 7'b0100011, 7'b0101111,
                              7'b0000111, 7'b0100111};
   int         id_tab [5] = '{1, 2, 3, 4, 4};

   function automatic int model_id(input logic [6:0] op, input logic rst);
      int id;
      id = 0;
      if (!rst)
         for (int k = 0; k < 5; k++)
            if (op == op_tab[k]) id = id_tab[k];
      return id;
   endfunction

   task automatic clear_inputs();
      for (int k = 0; k < 4; k++) begin
         ce[k] = 0; rd[k] = 0; wr[k] = 0; addr[k] = '0; dwr[k] = '0;
      end
      iRAM_DATA_RD = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      iRST = 1; OPCODE = 7'b0000011; ce[0] = 1; addr[0] = 8'h10;
      #2;
      checks++;
      if (oRAM_CE !== 1'b0) begin
         errors++; $display("FAIL reset_ce got %b exp 0", oRAM_CE);
      end
      checks++;
      if (oRAM_ADDR !== 8'h00) begin
         errors++; $display("FAIL reset_addr got %h exp 00", oRAM_ADDR);
      end
      @(posedge iCLK); #1;
      checks++;
      if (oSEL !== 3'd0) begin
         errors++; $display("FAIL reset_sel got %0d exp 0", oSEL);
      end
      iRST = 0;
   endtask

   task automatic test_load();
      clear_inputs();
      OPCODE = 7'b0000011;
      ce[0] = 1; rd[0] = 1; addr[0] = 8'h24;
      iRAM_DATA_RD = 32'hDEADBEEF;
      #2;
      checks++;
      if (oRAM_ADDR !== 8'h24 || oRAM_RD !== 1'b1) begin
         errors++;
         $display("FAIL load_ctl got addr %h rd %b exp 24 1", oRAM_ADDR, oRAM_RD);
      end
      checks++;
      if (rdo[0] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL load_rd_i got %h exp deadbeef", rdo[0]);
      end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (rdo[k] !== 32'h0) begin
            errors++; $display("FAIL load_rd_other%0d got %h exp 0", k, rdo[k]);
         end
      end
      @(posedge iCLK); #1;
      checks++;
      if (oSEL !== 3'd1) begin
         errors++; $display("FAIL load_sel got %0d exp 1", oSEL);
      end
   endtask

   task automatic test_store();
      clear_inputs();
      OPCODE = 7'b0100011;
      wr[1] = 1; addr[1] = 8'h08; dwr[1] = 32'h12345678;
      ce[0] = 1; rd[0] = 1; addr[0] = 8'hFF;
      #2;
      checks++;
      if (oRAM_WR !== 1'b1 || oRAM_ADDR !== 8'h08 ||
          oRAM_DATA_WR !== 32'h12345678) begin
         errors++;
         $display("FAIL store_out got wr %b addr %h data %h exp 1 08 12345678",
                  oRAM_WR, oRAM_ADDR, oRAM_DATA_WR);
      end
      @(posedge iCLK); #1;
      checks++;
      if (oSEL !== 3'd2) begin
         errors++; $display("FAIL store_sel got %0d exp 2", oSEL);
      end
   endtask

   task automatic test_atomic();
      clear_inputs();
      OPCODE = 7'b0101111;
      ce[2] = 1; rd[2] = 1; wr[2] = 1; addr[2] = 8'h40; dwr[2] = 32'h5;
      iRAM_DATA_RD = 32'h7;
      #2;
      checks++;
      if (oRAM_RD !== 1'b1 || oRAM_WR !== 1'b1 || oRAM_DATA_WR !== 32'h5) begin
         errors++;
         $display("FAIL amo_ctl got rd %b wr %b data %h exp 1 1 5",
                  oRAM_RD, oRAM_WR, oRAM_DATA_WR);
      end
      checks++;
      if (rdo[2] !== 32'h7) begin
         errors++; $display("FAIL amo_rd got %h exp 7", rdo[2]);
      end
      @(posedge iCLK); #1;
      checks++;
      if (oSEL !== 3'd3) begin
         errors++; $display("FAIL amo_sel got %0d exp 3", oSEL);
      end
   endtask

   task automatic test_fp();
      logic [6:0] ops [2] = '{7'b0000111, 7'b0100111};
      for (int j = 0; j < 2; j++) begin
         clear_inputs();
         OPCODE = ops[j];
         ce[3] = 1; addr[3] = 8'h0C;
         #2;
         checks++;
         if (oRAM_ADDR !== 8'h0C) begin
            errors++; $display("FAIL fp%0d_addr got %h exp 0c", j, oRAM_ADDR);
         end
         @(posedge iCLK); #1;
         checks++;
         if (oSEL !== 3'd4) begin
            errors++; $display("FAIL fp%0d_sel got %0d exp 4", j, oSEL);
         end
      end
   endtask

   task automatic test_none();
      OPCODE = 7'b0110011;
      for (int k = 0; k < 4; k++) begin
         ce[k] = 1; rd[k] = 1; wr[k] = 1;
         addr[k] = 8'(8'h11 * (k + 1)); dwr[k] = 32'hA5A50000 + k;
      end
      iRAM_DATA_RD = 32'hCAFEF00D;
      #2;
      checks++;
      if ({oRAM_CE, oRAM_RD, oRAM_WR} !== 3'b000 || oRAM_ADDR !== '0 ||
          oRAM_DATA_WR !== '0) begin
         errors++;
         $display("FAIL none_out got ctl %b%b%b addr %h data %h exp zeros",
                  oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA_WR);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rdo[k] !== '0) begin
            errors++; $display("FAIL none_rd%0d got %h exp 0", k, rdo[k]);
         end
      end
      @(posedge iCLK); #1;
      checks++;
      if (oSEL !== 3'd0) begin
         errors++; $display("FAIL none_sel got %0d exp 0", oSEL);
      end
   endtask

   task automatic test_random();
      int            id;
      logic          e_ce, e_rd, e_wr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_dwr, e_rdo;
      for (int n = 0; n < 300; n++) begin
         iRST = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) OPCODE = 7'($urandom);
         else OPCODE = op_tab[$urandom_range(0, 4)];
         for (int k = 0; k < 4; k++) begin
            ce[k] = 1'($urandom); rd[k] = 1'($urandom); wr[k] = 1'($urandom);
            addr[k] = 8'($urandom); dwr[k] = $urandom;
         end
         iRAM_DATA_RD = $urandom;
         id = model_id(OPCODE, iRST);
         e_ce = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_dwr = '0;
         if (id != 0) begin
            e_ce = ce[id-1]; e_rd = rd[id-1]; e_wr = wr[id-1];
            e_addr = addr[id-1]; e_dwr = dwr[id-1];
         end
         #2;
         checks++;
         if ({oRAM_CE, oRAM_RD, oRAM_WR} !== {e_ce, e_rd, e_wr} ||
             oRAM_ADDR !== e_addr || oRAM_DATA_WR !== e_dwr) begin
            errors++;
            $display("FAIL rnd%0d_ram op %b rst %b got %b%b%b %h %h exp %b%b%b %h %h",
                     n, OPCODE, iRST, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR,
                     oRAM_DATA_WR, e_ce, e_rd, e_wr, e_addr, e_dwr);
         end
         for (int k = 0; k < 4; k++) begin
            e_rdo = (id == k + 1) ? iRAM_DATA_RD : '0;
            checks++;
            if (rdo[k] !== e_rdo) begin
               errors++;
               $display("FAIL rnd%0d_rd%0d got %h exp %h", n, k, rdo[k], e_rdo);
            end
         end
         @(posedge iCLK); #1;
         checks++;
         if (oSEL !== 3'(id)) begin
            errors++; $display("FAIL rnd%0d_sel got %0d exp %0d", n, oSEL, id);
         end
      end
      iRST = 0;
   endtask

   initial begin
      iRST = 1;
      OPCODE = '0;
      clear_inputs();
      test_reset();
      test_load();
      test_store();
      test_atomic();
      test_fp();
      test_none();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
